// File: rtl/motor_uart_tx.sv
// 8N1 UART transmitter with a 4-entry byte FIFO for the motor telemetry link.
// Define MOTOR_UART_TX_PARITY_EN to add an even-parity bit between D7 and stop.
module motor_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 400
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Wr_En,
  input  logic [7:0] Data_In,
  output logic       Full,
  output logic       Empty,
  output logic       Busy,
  output logic       Ovf,
  output logic       TX
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef MOTOR_UART_TX_PARITY_EN
    S_PAR,
`endif
    S_STOP
  } state_t;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  state_t      state_q, state_d;
  logic [7:0]  fifo_q [4];
  logic [7:0]  fifo_d [4];
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  count_q, count_d;
  logic        full_q, full_d;
  logic        empty_q, empty_d;
  logic        ovf_q, ovf_d;
  logic        busy_q, busy_d;
  logic        tx_q, tx_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
`ifdef MOTOR_UART_TX_PARITY_EN
  logic        par_q, par_d;
`endif

  logic       push;
  logic       pop;
  logic       baud_end;
  logic [7:0] head;

  assign head     = fifo_q[rd_ptr_q];
  assign baud_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d   = state_q;
    fifo_d    = fifo_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    ovf_d     = ovf_q;
    tx_d      = tx_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
`ifdef MOTOR_UART_TX_PARITY_EN
    par_d     = par_q;
`endif
    push      = Wr_En && !full_q;
    pop       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!empty_q) begin
          pop     = 1'b1;
          shift_d = head;
          baud_d  = '0;
          tx_d    = 1'b0;
          state_d = S_START;
`ifdef MOTOR_UART_TX_PARITY_EN
          par_d   = ^head;
`endif
        end
      end
      S_START: begin
        if (baud_end) begin
          baud_d    = '0;
          tx_d      = shift_q[0];
          bit_idx_d = '0;
          state_d   = S_DATA;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) begin
`ifdef MOTOR_UART_TX_PARITY_EN
            tx_d    = par_q;
            state_d = S_PAR;
`else
            tx_d    = 1'b1;
            state_d = S_STOP;
`endif
          end else begin
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
`ifdef MOTOR_UART_TX_PARITY_EN
      S_PAR: begin
        if (baud_end) begin
          baud_d  = '0;
          tx_d    = 1'b1;
          state_d = S_STOP;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
`endif
      S_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          // chain straight into the next start bit when data is waiting
          if (!empty_q) begin
            pop     = 1'b1;
            shift_d = head;
            tx_d    = 1'b0;
            state_d = S_START;
`ifdef MOTOR_UART_TX_PARITY_EN
            par_d   = ^head;
`endif
          end else begin
            tx_d    = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase

    if (push) begin
      fifo_d[wr_ptr_q] = Data_In;
      wr_ptr_d         = wr_ptr_q + 2'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end
    if (Wr_En && full_q) begin
      ovf_d = 1'b1;
    end

    count_d = count_q + {2'b00, push} - {2'b00, pop};
    full_d  = (count_d == 3'd4);
    empty_d = (count_d == 3'd0);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      tx_q      <= 1'b1;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
`ifdef MOTOR_UART_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      fifo_q    <= fifo_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      ovf_q     <= ovf_d;
      busy_q    <= busy_d;
      tx_q      <= tx_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
`ifdef MOTOR_UART_TX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  assign Full  = full_q;
  assign Empty = empty_q;
  assign Busy  = busy_q;
  assign Ovf   = ovf_q;
  assign TX    = tx_q;

endmodule

// File: tb/tb_motor_uart_tx.sv
// Bench for motor_uart_tx: frame-schedule reference model, directed and random writes.
// Two instances: fast (4 clocks/bit) for most scenarios, slow (400) for bit timing.
module tb_motor_uart_tx;

  localparam int CPB   = 4;
  localparam int CPB_S = 400;
`ifdef MOTOR_UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, wr;
  logic [7:0] din;
  logic       full, empty, busy, ovf, tx;
  logic       rst_s, wr_s;
  logic [7:0] din_s;
  logic       full_s, empty_s, busy_s, ovf_s, tx_s;

  motor_uart_tx #(.CLKS_PER_BIT(CPB)) u_fast (
    .CLK(clk), .RST(rst), .Wr_En(wr), .Data_In(din),
    .Full(full), .Empty(empty), .Busy(busy), .Ovf(ovf), .TX(tx)
  );

  motor_uart_tx #(.CLKS_PER_BIT(CPB_S)) u_slow (
    .CLK(clk), .RST(rst_s), .Wr_En(wr_s), .Data_In(din_s),
    .Full(full_s), .Empty(empty_s), .Busy(busy_s), .Ovf(ovf_s), .TX(tx_s)
  );

  int t = 0;
  int checks = 0;
  int failures = 0;

  // model: each accepted byte gets a frame start edge; the line is a
  // concatenation of frames, idle high elsewhere
  int         fs [1024];
  logic [7:0] fd [1024];
  int         n = 0;
  logic       m_ovf = 1'b0;
  int         s_slow = -1;

  function automatic logic frame_bit(input logic [7:0] x, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return x[b-1];
`ifdef MOTOR_UART_TX_PARITY_EN
    if (b == 9) return ^x;
`endif
    return 1'b1;
  endfunction

  function automatic int m_count(input int x);
    int c = n;
    for (int i = 0; i < n; i++) if (fs[i] <= x) c--;
    return c;
  endfunction

  task automatic exp_line(input int x, output logic etx, output logic eb);
    etx = 1'b1;
    eb  = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (x >= fs[i] && x < fs[i] + FB * CPB) begin
        etx = frame_bit(fd[i], (x - fs[i]) / CPB);
        eb  = 1'b1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      if (failures <= 20)
        $error("FAIL %s t=%0d observed=%0b expected=%0b", tag, t, obs, exp);
    end
  endtask

  task automatic model_edge();
    int s;
    if (rst) begin
      n = 0;
      m_ovf = 1'b0;
    end else if (wr) begin
      if (m_count(t - 1) < 4) begin
        s = t + 1;
        if (n > 0 && t + 1 <= fs[n-1] + FB * CPB) s = fs[n-1] + FB * CPB;
        fs[n] = s;
        fd[n] = din;
        n++;
      end else begin
        m_ovf = 1'b1;
      end
    end
    if (rst_s) s_slow = -1;
    else if (wr_s && s_slow < 0) s_slow = t + 1;
  endtask

  task automatic compare();
    logic etx, eb, es, ebs;
    int c;
    exp_line(t, etx, eb);
    c = m_count(t);
    chk("tx", tx, etx);
    chk("busy", busy, eb);
    chk("full", full, c == 4);
    chk("empty", empty, c == 0);
    chk("ovf", ovf, m_ovf);
    es  = 1'b1;
    ebs = 1'b0;
    if (s_slow >= 0 && t >= s_slow && t < s_slow + FB * CPB_S) begin
      es  = frame_bit(8'h0F, (t - s_slow) / CPB_S);
      ebs = 1'b1;
    end
    chk("tx_slow", tx_s, es);
    chk("busy_slow", busy_s, ebs);
    chk("empty_slow", empty_s, !(s_slow >= 0 && t == s_slow - 1));
    chk("full_slow", full_s, 1'b0);
    chk("ovf_slow", ovf_s, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    t++;
    model_edge();
    #1;
    compare();
  endtask

  task automatic drain();
    logic etx, eb;
    int k = 0;
    exp_line(t, etx, eb);
    while ((m_count(t) != 0 || eb) && k < 3000) begin
      tick();
      k++;
      exp_line(t, etx, eb);
    end
    if (k >= 3000) begin
      checks++;
      failures++;
      $error("FAIL drain_timeout t=%0d observed=busy expected=idle", t);
    end
    repeat (3) tick();
  endtask

  task automatic put(input logic [7:0] b);
    wr  = 1'b1;
    din = b;
    tick();
    wr  = 1'b0;
  endtask

  logic [7:0] burst [6] = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h11, 8'h22};

  initial begin
    int e, s0, dens, k;
    rst = 1'b1; wr = 1'b0; din = '0;
    rst_s = 1'b1; wr_s = 1'b0; din_s = '0;
    repeat (3) tick();
    rst = 1'b0;
    rst_s = 1'b0;
    tick();

    wr_s = 1'b1;
    din_s = 8'h0F;
    wr = 1'b1;
    din = 8'h80;
    tick();
    wr_s = 1'b0;
    wr = 1'b0;
    drain();

    foreach (burst[i]) begin
      wr  = 1'b1;
      din = burst[i];
      tick();
    end
    wr = 1'b0;
    drain();

    put(8'h0F);
    drain();
    put(8'h07);
    drain();

    // push lands on the edge where the stop bit ends and the next byte pops
    put(8'h12);
    e = fs[n-1] + FB * CPB;
    repeat (5) tick();
    put(8'h34);
    while (t + 1 < e) tick();
    put(8'h56);
    drain();

    put(8'h55);
    s0 = fs[n-1];
    while (t < s0 + 4 * CPB + 1) tick();
    rst = 1'b1;
    wr  = 1'b1;
    din = 8'h99;
    tick();
    rst = 1'b0;
    wr  = 1'b0;
    repeat (60) tick();

    dens = 10;
    for (int i = 0; i < 1500; i++) begin
      if (i % 300 == 0) dens = int'($urandom_range(3, 70));
      wr  = (int'($urandom_range(0, 99)) < dens);
      din = 8'($urandom);
      rst = ($urandom_range(0, 599) == 0);
      tick();
    end
    rst = 1'b0;
    wr  = 1'b0;
    drain();

    k = 0;
    while (t < s_slow + FB * CPB_S + 5 && k < 10000) begin
      tick();
      k++;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
